// File: rtl/score_life_keeper_if.sv
// Request and status bundle between the game controller and the score/life keeper.
// The controller drives requests through master; the keeper sits on slave.
interface score_life_keeper_if;
    logic        enableAddScore;
    logic        enableRemoveScore;
    logic [0:23] scoreAmount;
    logic        enableAddLife;
    logic        enableRemoveLife;
    logic [0:2]  lifeAmount;
    logic        requestTime;
    logic [0:10] timeLenReq;
    logic        oneSecPulse;
    logic [0:23] score;
    logic [2:0]  lives;
    logic [10:0] timeLeft;
    logic        scoreBusy;
    logic        scoreDropped;
    logic        timeUp;
    logic        gameOver;

    modport master (
        output enableAddScore, enableRemoveScore, scoreAmount,
        output enableAddLife, enableRemoveLife, lifeAmount,
        output requestTime, timeLenReq, oneSecPulse,
        input  score, lives, timeLeft, scoreBusy, scoreDropped, timeUp, gameOver
    );

    modport slave (
        input  enableAddScore, enableRemoveScore, scoreAmount,
        input  enableAddLife, enableRemoveLife, lifeAmount,
        input  requestTime, timeLenReq, oneSecPulse,
        output score, lives, timeLeft, scoreBusy, scoreDropped, timeUp, gameOver
    );
endinterface

// File: rtl/score_life_keeper.sv
// Player score (digit-serial BCD with a one-entry pending buffer), lives and
// countdown timer, plus the sticky game-over indication.
module score_life_keeper #(
    parameter int INIT_LIVES = 3,
    parameter int INIT_TIME  = 300
) (
    input  logic               clk,
    input  logic               resetN,
    score_life_keeper_if.slave bus
);
    localparam int NUM_DIGITS = 6;

    // Element [0] is the least significant digit.
    typedef logic [NUM_DIGITS-1:0][3:0] bcd_t;
    typedef struct packed {
        logic sub;
        bcd_t amt;
    } score_req_t;
    typedef enum logic [1:0] {IDLE, DIGIT, COMMIT} state_t;

    state_t     state_q, state_d;
    score_req_t cur_q, cur_d, pend_q, pend_d;
    logic       pend_vld_q, pend_vld_d;
    bcd_t       score_q, score_d, res_q, res_d;
    logic       carry_q, carry_d;
    logic [2:0] idx_q, idx_d;
    logic       dropped_q, dropped_d;
    logic       game_over_q;
    logic [2:0] lives_q, lives_d;
    logic [10:0] time_q, time_d;
    logic       time_up_q, time_up_d;

    bcd_t       amt_in;
    logic [2:0] life_amt;
    logic [10:0] time_len;
    score_req_t add_req, rem_req;
    logic       add_v, rem_v, start, drop;

    assign amt_in   = bus.scoreAmount;
    assign life_amt = bus.lifeAmount;
    assign time_len = bus.timeLenReq;
    assign add_req  = '{sub: 1'b0, amt: amt_in};
    assign rem_req  = '{sub: 1'b1, amt: amt_in};
    assign add_v    = bus.enableAddScore & ~game_over_q;
    assign rem_v    = bus.enableRemoveScore & ~game_over_q;

    // One BCD digit of the in-flight operation; 5-bit result covers carry and borrow.
    logic [3:0] a_dig, b_dig, d_dig;
    logic [4:0] dsum;
    logic       d_c;
    always_comb begin
        a_dig = score_q[idx_q];
        b_dig = cur_q.amt[idx_q];
        d_c   = 1'b0;
        if (!cur_q.sub) begin
            dsum = {1'b0, a_dig} + {1'b0, b_dig} + {4'd0, carry_q};
            if (dsum > 5'd9) begin
                d_dig = 4'(dsum - 5'd10);
                d_c   = 1'b1;
            end else begin
                d_dig = dsum[3:0];
            end
        end else begin
            dsum = {1'b0, a_dig} - {1'b0, b_dig} - {4'd0, carry_q};
            if (dsum[4]) begin
                d_dig = 4'(dsum + 5'd10);
                d_c   = 1'b1;
            end else begin
                d_dig = dsum[3:0];
            end
        end
    end

    // Arbitration: pending, then add, then remove; first winner starts when idle,
    // the next one takes the pending slot, anything left is dropped.
    always_comb begin
        cur_d      = cur_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        dropped_d  = dropped_q;
        start      = 1'b0;
        drop       = 1'b0;
        if (state_q == IDLE) begin
            if (pend_vld_q && !game_over_q) begin
                cur_d      = pend_q;
                start      = 1'b1;
                pend_vld_d = 1'b0;
                if (add_v) begin
                    pend_d     = add_req;
                    pend_vld_d = 1'b1;
                    drop       = rem_v;
                end else if (rem_v) begin
                    pend_d     = rem_req;
                    pend_vld_d = 1'b1;
                end
            end else if (add_v) begin
                cur_d = add_req;
                start = 1'b1;
                if (rem_v) begin
                    pend_d     = rem_req;
                    pend_vld_d = 1'b1;
                end
            end else if (rem_v) begin
                cur_d = rem_req;
                start = 1'b1;
            end
        end else begin
            if (add_v) begin
                if (!pend_vld_q) begin
                    pend_d     = add_req;
                    pend_vld_d = 1'b1;
                    drop       = rem_v;
                end else begin
                    drop = 1'b1;
                end
            end else if (rem_v) begin
                if (!pend_vld_q) begin
                    pend_d     = rem_req;
                    pend_vld_d = 1'b1;
                end else begin
                    drop = 1'b1;
                end
            end
        end
        if (game_over_q) pend_vld_d = 1'b0;
        if (drop) dropped_d = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        score_d = score_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = DIGIT;
                    carry_d = 1'b0;
                    idx_d   = 3'd0;
                end
            end
            DIGIT: begin
                res_d[idx_q] = d_dig;
                carry_d      = d_c;
                idx_d        = idx_q + 3'd1;
                if (idx_q == 3'(NUM_DIGITS - 1)) state_d = COMMIT;
            end
            COMMIT: begin
                state_d = IDLE;
                if (carry_q) score_d = cur_q.sub ? '0 : {NUM_DIGITS{4'd9}};
                else         score_d = res_q;
            end
            default: state_d = IDLE;
        endcase
    end

    logic [3:0]  life_add;
    logic [11:0] t_add;
    logic [10:0] t_sat;
    always_comb begin
        life_add = {1'b0, lives_q} + {1'b0, life_amt};
        lives_d  = lives_q;
        if (!game_over_q && bus.enableAddLife && !bus.enableRemoveLife)
            lives_d = life_add[3] ? 3'd7 : life_add[2:0];
        else if (!game_over_q && bus.enableRemoveLife && !bus.enableAddLife)
            lives_d = (life_amt > lives_q) ? 3'd0 : lives_q - life_amt;

        // Ticks keep counting after game over; only requests are frozen.
        t_add     = {1'b0, time_q} + ((bus.requestTime && !game_over_q) ? {1'b0, time_len} : 12'd0);
        t_sat     = t_add[11] ? 11'd2047 : t_add[10:0];
        time_d    = (bus.oneSecPulse && t_sat != 11'd0) ? t_sat - 11'd1 : t_sat;
        time_up_d = bus.oneSecPulse && (time_q == 11'd1) && (time_d == 11'd0);
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_q     <= IDLE;
            cur_q       <= '0;
            pend_q      <= '0;
            pend_vld_q  <= 1'b0;
            score_q     <= '0;
            res_q       <= '0;
            carry_q     <= 1'b0;
            idx_q       <= 3'd0;
            dropped_q   <= 1'b0;
            game_over_q <= 1'b0;
            lives_q     <= 3'(INIT_LIVES);
            time_q      <= 11'(INIT_TIME);
            time_up_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            pend_q      <= pend_d;
            pend_vld_q  <= pend_vld_d;
            score_q     <= score_d;
            res_q       <= res_d;
            carry_q     <= carry_d;
            idx_q       <= idx_d;
            dropped_q   <= dropped_d;
            game_over_q <= game_over_q | (lives_q == 3'd0) | (time_q == 11'd0);
            lives_q     <= lives_d;
            time_q      <= time_d;
            time_up_q   <= time_up_d;
        end
    end

    assign bus.score        = score_q;
    assign bus.lives        = lives_q;
    assign bus.timeLeft     = time_q;
    assign bus.scoreBusy    = (state_q != IDLE);
    assign bus.scoreDropped = dropped_q;
    assign bus.timeUp       = time_up_q;
    assign bus.gameOver     = game_over_q;
endmodule

// File: tb/tb_score_life_keeper.sv
// Bench for score_life_keeper: directed scenarios then random traffic, every
// cycle compared against a decimal/queue reference model.
module tb_score_life_keeper;
    localparam int INIT_LIVES = 3;
    localparam int INIT_TIME  = 300;

    logic clk = 1'b0;
    logic resetN;
    always #5 clk = ~clk;

    score_life_keeper_if bus();

    score_life_keeper #(.INIT_LIVES(INIT_LIVES), .INIT_TIME(INIT_TIME)) dut (
        .clk(clk),
        .resetN(resetN),
        .bus(bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [23:0] to_bcd(input int v);
        logic [23:0] r;
        int x;
        x = v;
        for (int i = 0; i < 6; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic int from_bcd(input logic [23:0] b);
        int r;
        r = 0;
        for (int i = 5; i >= 0; i--) r = r * 10 + int'(b[4*i +: 4]);
        return r;
    endfunction

    // Reference model: score as a decimal integer, requests as signed deltas.
    int m_score, m_busy, m_cur, m_lives, m_time;
    bit m_drop, m_tu, m_go;
    int m_pend[$];
    int busy_seen, tu_seen;

    task automatic model_step();
        int incoming[$];
        int srcs[$];
        int amt, la, t;
        bit go_now;
        if (!resetN) begin
            m_score = 0; m_busy = 0; m_pend.delete(); m_drop = 0;
            m_lives = INIT_LIVES; m_time = INIT_TIME; m_tu = 0; m_go = 0;
            return;
        end
        go_now = m_go;
        m_go = m_go || (m_lives == 0) || (m_time == 0);

        la = int'(bus.lifeAmount);
        if (!go_now && bus.enableAddLife && !bus.enableRemoveLife)
            m_lives = (m_lives + la > 7) ? 7 : m_lives + la;
        else if (!go_now && bus.enableRemoveLife && !bus.enableAddLife)
            m_lives = (m_lives - la < 0) ? 0 : m_lives - la;

        t = m_time;
        if (!go_now && bus.requestTime) t = (t + int'(bus.timeLenReq) > 2047) ? 2047 : t + int'(bus.timeLenReq);
        if (bus.oneSecPulse && t > 0) t--;
        m_tu = bus.oneSecPulse && (m_time == 1) && (t == 0);
        m_time = t;

        amt = from_bcd(bus.scoreAmount);
        if (!go_now) begin
            if (bus.enableAddScore) incoming.push_back(amt);
            if (bus.enableRemoveScore) incoming.push_back(-amt);
        end
        if (go_now) m_pend.delete();
        if (m_busy == 0) begin
            foreach (m_pend[i]) srcs.push_back(m_pend[i]);
            m_pend.delete();
            foreach (incoming[i]) srcs.push_back(incoming[i]);
            if (srcs.size() > 0) begin
                m_cur = srcs.pop_front();
                m_busy = 7;
                if (srcs.size() > 0) m_pend.push_back(srcs.pop_front());
                if (srcs.size() > 0) m_drop = 1;
            end
        end else begin
            m_busy--;
            if (m_busy == 0) begin
                m_score = m_score + m_cur;
                if (m_score > 999999) m_score = 999999;
                if (m_score < 0) m_score = 0;
            end
            foreach (incoming[i]) begin
                if (m_pend.size() == 0) m_pend.push_back(incoming[i]);
                else m_drop = 1;
            end
        end
    endtask

    task automatic clear_pulses();
        bus.enableAddScore = 0; bus.enableRemoveScore = 0;
        bus.enableAddLife = 0; bus.enableRemoveLife = 0;
        bus.requestTime = 0; bus.oneSecPulse = 0;
    endtask

    task automatic tick_cycle();
        model_step();
        @(negedge clk);
        if (bus.scoreBusy === 1'b1) busy_seen++;
        if (bus.timeUp === 1'b1) tu_seen++;
        chk("score", 32'(bus.score), 32'(to_bcd(m_score)));
        chk("lives", 32'(bus.lives), 32'(m_lives));
        chk("timeLeft", 32'(bus.timeLeft), 32'(m_time));
        chk("scoreBusy", 32'(bus.scoreBusy), 32'(m_busy > 0));
        chk("scoreDropped", 32'(bus.scoreDropped), 32'(m_drop));
        chk("timeUp", 32'(bus.timeUp), 32'(m_tu));
        chk("gameOver", 32'(bus.gameOver), 32'(m_go));
        clear_pulses();
    endtask

    task automatic run(input int n);
        repeat (n) tick_cycle();
    endtask

    task automatic score_req(input bit add, input bit rem, input int amt);
        bus.scoreAmount = to_bcd(amt);
        bus.enableAddScore = add;
        bus.enableRemoveScore = rem;
        tick_cycle();
    endtask

    task automatic life_req(input bit add, input bit rem, input int amt);
        bus.lifeAmount = 3'(amt);
        bus.enableAddLife = add;
        bus.enableRemoveLife = rem;
        tick_cycle();
    endtask

    task automatic do_reset(input int n);
        resetN = 0;
        run(n);
        resetN = 1;
    endtask

    initial begin
        clear_pulses();
        bus.scoreAmount = '0; bus.lifeAmount = '0; bus.timeLenReq = '0;
        busy_seen = 0; tu_seen = 0;
        do_reset(2);
        chk("rst_score", 32'(bus.score), 32'h0);
        chk("rst_lives", 32'(bus.lives), 32'(INIT_LIVES));
        chk("rst_time", 32'(bus.timeLeft), 32'(INIT_TIME));

        // BCD carry across digits and busy window length.
        busy_seen = 0;
        score_req(1, 0, 95); run(7);
        chk("busy_len", 32'(busy_seen), 32'd7);
        busy_seen = 0;
        score_req(1, 0, 7); run(7);
        chk("busy_len2", 32'(busy_seen), 32'd7);
        chk("score_102", 32'(bus.score), 32'h000102);

        // Simultaneous add/remove plus a dropped third request.
        score_req(1, 0, 398); run(7);
        chk("score_500", 32'(bus.score), 32'h000500);
        score_req(1, 1, 40);
        score_req(1, 0, 5);
        chk("drop_flag", 32'(bus.scoreDropped), 32'd1);
        run(6);
        chk("score_540", 32'(bus.score), 32'h000540);
        run(8);
        chk("score_back_500", 32'(bus.score), 32'h000500);

        // Saturation and floor.
        score_req(1, 0, 999490); run(7);
        chk("score_999990", 32'(bus.score), 32'h999990);
        score_req(1, 0, 20); run(7);
        chk("score_sat", 32'(bus.score), 32'h999999);
        score_req(0, 1, 999989); run(7);
        chk("score_10", 32'(bus.score), 32'h000010);
        score_req(0, 1, 160); run(7);
        chk("score_floor", 32'(bus.score), 32'h0);

        // Lives to zero, game over freezes requests.
        life_req(0, 1, 1); chk("lives_2", 32'(bus.lives), 32'd2);
        life_req(0, 1, 1); chk("lives_1", 32'(bus.lives), 32'd1);
        life_req(0, 1, 1); chk("lives_0", 32'(bus.lives), 32'd0);
        run(1);
        chk("go_lives", 32'(bus.gameOver), 32'd1);
        life_req(1, 0, 1); chk("lives_frozen", 32'(bus.lives), 32'd0);
        score_req(1, 0, 5); run(8);
        chk("score_frozen", 32'(bus.score), 32'h0);

        // Timer run-down with a coincident request and tick.
        do_reset(1);
        repeat (INIT_TIME - 2) begin
            bus.oneSecPulse = 1;
            tick_cycle();
        end
        chk("time_2", 32'(bus.timeLeft), 32'd2);
        bus.requestTime = 1; bus.timeLenReq = 11'd60; bus.oneSecPulse = 1;
        tick_cycle();
        chk("time_61", 32'(bus.timeLeft), 32'd61);
        tu_seen = 0;
        repeat (61) begin
            bus.oneSecPulse = 1;
            tick_cycle();
        end
        chk("time_0", 32'(bus.timeLeft), 32'd0);
        run(3);
        chk("timeup_once", 32'(tu_seen), 32'd1);
        chk("go_time", 32'(bus.gameOver), 32'd1);

        // Reset aborts an in-flight operation.
        do_reset(1);
        score_req(1, 0, 123456); run(2);
        resetN = 0;
        tick_cycle();
        resetN = 1;
        chk("abort_score", 32'(bus.score), 32'h0);
        chk("abort_busy", 32'(bus.scoreBusy), 32'd0);
        chk("abort_lives", 32'(bus.lives), 32'(INIT_LIVES));
        chk("abort_time", 32'(bus.timeLeft), 32'(INIT_TIME));
        run(8);
        chk("abort_stays0", 32'(bus.score), 32'h0);

        // Random traffic.
        for (int c = 0; c < 4000; c++) begin
            resetN = !(($urandom_range(0, 399) == 0) || (bus.gameOver && $urandom_range(0, 29) == 0));
            bus.scoreAmount = to_bcd(($urandom_range(0, 1) == 1) ? $urandom_range(0, 999) : $urandom_range(0, 999999));
            bus.enableAddScore    = ($urandom_range(0, 7) == 0);
            bus.enableRemoveScore = ($urandom_range(0, 9) == 0);
            bus.lifeAmount        = 3'($urandom_range(0, 7));
            bus.enableAddLife     = ($urandom_range(0, 15) == 0);
            bus.enableRemoveLife  = ($urandom_range(0, 19) == 0);
            bus.timeLenReq        = 11'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 2047) : $urandom_range(0, 20));
            bus.requestTime       = ($urandom_range(0, 15) == 0);
            bus.oneSecPulse       = ($urandom_range(0, 1) == 0);
            tick_cycle();
        end
        resetN = 1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
